rle_decompressor: RTL and testbench
===================================

# rle_decompressor

Parametrised run-length bitmap decompressor for the DCNN accelerator I/O path. Consumes a stream of run-length tokens (first token carries the initial bit value, each later token is the length of a run of identical bits, with the bit value alternating between runs) and rebuilds the packed bitmap as DATA_W-bit words on a valid/ready output toward the DMA. It is the successor to the fixed 16-bit decompressor: width is generic, frame length is explicit, both sides have handshakes, runs are expanded several bits per cycle, and overrun is detected.

## Interface
- DATA_W, default 16: output word width in bits; power of two, ≥ 8.
- CNT_W, default 16: run-length token width.
- TOT_W, default 32: width of the frame bit-count.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- total_bits  in  TOT_W  decompressed frame length in bits; latched on start.
- in_valid  in  1  token valid.
- in_data  in  CNT_W  token: header (bit 0 = initial bit value) or run length.
- in_ready  out  1  token accepted when in_valid && in_ready.
- out_valid  out  1  output word valid.
- out_data  out  DATA_W  packed bitmap word; first decompressed bit in bit 0.
- out_ready  in  1  DMA accepts word when out_valid && out_ready.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the frame completes.
- err  out  1  sticky overrun flag; cleared on start.

## Operation
- Registers: word[DATA_W], idx (0..DATA_W-1), run[CNT_W], remaining[TOT_W], cur_bit.
- States: IDLE, HDR, LOAD, FILL, OUT, DONE.
- IDLE: on start, latch remaining=total_bits, clear word, idx=0, err=0. If total_bits==0, go to DONE; otherwise go to HDR. A start pulse in any other state is ignored.
- HDR: in_ready=1. On handshake, set cur_bit=in_data[0] and go to LOAD.
- LOAD: in_ready=1. On handshake, take in_data as the run length.
  - Run of 0: toggle cur_bit and stay in LOAD.
  - Run greater than remaining: set err=1 and truncate the run to remaining.
  - Then go to FILL.
- FILL: in_ready=0. Each cycle:
  - n = min(run, DATA_W-idx, remaining).
  - Write cur_bit into word[idx .. idx+n-1]; idx+=n, run-=n, remaining-=n.
  - If idx reaches DATA_W or remaining reaches 0: go to OUT. Bits not yet written stay 0.
  - Else, if run reaches 0: toggle cur_bit and go to LOAD.
  - When run reaches 0 in the same cycle the word completes, cur_bit is still toggled.
- OUT: out_valid=1 and out_data=word, both held stable until the handshake. On handshake, clear word and set idx=0, then:
  - remaining==0: go to DONE.
  - else run>0: go to FILL.
  - else: go to LOAD.
- DONE: done=1 for one cycle, then IDLE. Tokens are never accepted outside HDR/LOAD, so surplus tokens after completion stay pending upstream.
- All outputs are registered or decoded from state only. No combinational path from in_valid or out_ready to any output.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, done=0, err=0. State goes to IDLE and all counters clear.
- Reset mid-frame aborts immediately. A partial word is discarded and is never presented.
- Token accepted at edge k; the first FILL cycle is k→k+1. A run needs ceil(span/DATA_W) FILL cycles plus one OUT cycle per completed word.
- out_valid rises in the cycle after the FILL edge that completes a word. Minimum word-to-word spacing is 2 cycles (FILL, OUT).
- done pulses the cycle after the final OUT handshake, or the cycle after start when total_bits==0.

## Test plan
- DATA_W=16: start, total 16; tokens 1, 3, 5, 8 → one word 0xFF07, then done. err=0.
- Total 32; tokens 0, 20, 12 → words 0x0000 and 0xFFF0; FILL spans the word boundary with no token consumed between words.
- Partial flush: total 10; tokens 1, 10 → word 0x03FF (upper bits 0), done. A surplus token present on in_valid is not accepted.
- Zero run: total 16; tokens 0, 0, 16 → 0xFFFF. Overrun: total 8; tokens 0, 4, 9 → 0x00F0, err=1 until the next start.
- Backpressure: hold out_ready=0 for 5 cycles with a word pending → out_data stable, in_ready=0. Then release → a single handshake.
- Assert rst mid-FILL → all outputs at reset values next cycle. A new start then gives a clean 0xFF07 frame (first scenario).

Source files
------------

// File: rtl/rle_decompressor.sv
// rle_decompressor
// Rebuilds a packed bitmap from a run-length token stream. The first token
// of a frame carries the initial bit value in bit 0; every later token is a
// run length, and the bit value alternates between runs. Runs are expanded
// up to DATA_W bits per cycle into DATA_W-bit words, first bit in bit 0.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   start        one-cycle frame start, honoured only while idle
//   total_bits   frame length in bits, latched on start
//   in_valid     token valid
//   in_data      token (header bit 0, or run length)
//   in_ready     token accepted when in_valid && in_ready
//   out_valid    output word valid
//   out_data     packed bitmap word
//   out_ready    downstream accepts word when out_valid && out_ready
//   busy         high whenever a frame is in progress
//   done         one-cycle pulse on frame completion
//   err          sticky overrun flag (a run exceeded the remaining bits),
//                cleared on start
module rle_decompressor #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16,
    parameter int TOT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [TOT_W-1:0]  total_bits,
    input  logic              in_valid,
    input  logic [CNT_W-1:0]  in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int IDX_W = $clog2(DATA_W);
    localparam int SP_W  = IDX_W + 1;
    localparam int WA    = (CNT_W > TOT_W) ? CNT_W : TOT_W;
    localparam int WW    = (WA > SP_W) ? WA : SP_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LOAD,
        S_FILL,
        S_OUT,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_word;
    logic [IDX_W-1:0]    r_idx;
    logic [CNT_W-1:0]    r_run;
    logic [TOT_W-1:0]    r_remaining;
    logic                r_cur_bit;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    logic [WW-1:0]       w_run_x;
    logic [WW-1:0]       w_rem_x;
    logic [WW-1:0]       w_space_x;
    logic [WW-1:0]       w_min_a;
    logic [WW-1:0]       w_n_x;
    logic [WW-1:0]       w_tok_x;
    logic [SP_W-1:0]     w_n;
    logic [SP_W-1:0]     w_idx_lo;
    logic [SP_W-1:0]     w_idx_sum;
    logic [DATA_W-1:0]   w_mask;
    logic [DATA_W-1:0]   w_word_next;
    logic [CNT_W-1:0]    w_run_next;
    logic [TOT_W-1:0]    w_rem_next;
    logic                w_word_full;
    logic                w_rem_zero;
    logic                w_run_zero;
    logic                w_overrun;

    // Bits written this FILL cycle: n = min(run, space left in word, remaining).
    // All three operands are compared in a common width so no truncation
    // can distort the minimum.
    always_comb begin
        w_run_x     = WW'(r_run);
        w_rem_x     = WW'(r_remaining);
        w_idx_lo    = SP_W'(r_idx);
        w_space_x   = WW'(SP_W'(DATA_W) - w_idx_lo);
        w_min_a     = (w_run_x < w_space_x) ? w_run_x : w_space_x;
        w_n_x       = (w_min_a < w_rem_x) ? w_min_a : w_rem_x;
        w_n         = SP_W'(w_n_x);
        w_idx_sum   = w_idx_lo + w_n;

        w_mask = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if ((SP_W'(i) >= w_idx_lo) && (SP_W'(i) < w_idx_sum)) begin
                w_mask[i] = 1'b1;
            end
        end

        // Unwritten bits are already zero, so writing a 0-run is a no-op.
        w_word_next = r_word | (r_cur_bit ? w_mask : '0);
        w_run_next  = r_run - CNT_W'(w_n);
        w_rem_next  = r_remaining - TOT_W'(w_n);
        w_word_full = (w_idx_sum == SP_W'(DATA_W));
        w_rem_zero  = (w_rem_next == '0);
        w_run_zero  = (w_run_next == '0);

        w_tok_x     = WW'(in_data);
        w_overrun   = (w_tok_x > w_rem_x);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_word      <= '0;
            r_idx       <= '0;
            r_run       <= '0;
            r_remaining <= '0;
            r_cur_bit   <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_remaining <= total_bits;
                        r_word      <= '0;
                        r_idx       <= '0;
                        r_run       <= '0;
                        r_err       <= 1'b0;
                        r_busy      <= 1'b1;
                        if (total_bits == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= S_HDR;
                            r_in_ready <= 1'b1;
                        end
                    end
                end

                S_HDR: begin
                    if (in_valid) begin
                        r_cur_bit <= in_data[0];
                        r_state   <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    if (in_valid) begin
                        if (in_data == '0) begin
                            r_cur_bit <= ~r_cur_bit;
                        end else begin
                            r_in_ready <= 1'b0;
                            r_state    <= S_FILL;
                            if (w_overrun) begin
                                // Remaining is below this run, so it fits CNT_W.
                                r_err <= 1'b1;
                                r_run <= CNT_W'(r_remaining);
                            end else begin
                                r_run <= in_data;
                            end
                        end
                    end
                end

                S_FILL: begin
                    r_word      <= w_word_next;
                    r_idx       <= w_idx_sum[IDX_W-1:0];
                    r_run       <= w_run_next;
                    r_remaining <= w_rem_next;
                    // The bit value flips whenever a run ends, even if the
                    // same cycle also completes the word.
                    if (w_run_zero) begin
                        r_cur_bit <= ~r_cur_bit;
                    end
                    if (w_word_full || w_rem_zero) begin
                        r_state     <= S_OUT;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_word_next;
                    end else if (w_run_zero) begin
                        r_state    <= S_LOAD;
                        r_in_ready <= 1'b1;
                    end
                end

                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_word      <= '0;
                        r_idx       <= '0;
                        if (r_remaining == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else if (r_run != '0) begin
                            r_state <= S_FILL;
                        end else begin
                            r_state    <= S_LOAD;
                            r_in_ready <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_rle_decompressor.sv
// tb_rle_decompressor
// Drives directed and randomized frames into rle_decompressor and compares
// every output word, token consumption, err and done/busy behaviour against
// a bit-list reference model of the run-length format.
module tb_rle_decompressor;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 16;
    localparam int TOT_W  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [TOT_W-1:0]  total_bits;
    logic              in_valid;
    logic [CNT_W-1:0]  in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              busy;
    logic              done;
    logic              err;

    rle_decompressor #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W),
        .TOT_W (TOT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .total_bits(total_bits),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [CNT_W-1:0]  tokq[$];
    logic [DATA_W-1:0] expq[$];
    bit                exp_err;
    int                exp_used;
    int                last_cyc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: expand the token list into a plain list of bits, stopping
    // once the frame length is reached, then cut the list into words.
    task automatic build_model(input int total);
        bit                bits[$];
        bit                cur;
        int                rem;
        int                take;
        logic [DATA_W-1:0] w;
        expq.delete();
        exp_err  = 1'b0;
        exp_used = 0;
        if (total == 0) return;
        cur      = tokq[0][0];
        exp_used = 1;
        for (int t = 1; t < tokq.size(); t++) begin
            if (bits.size() == total) break;
            exp_used++;
            rem  = total - bits.size();
            take = int'(tokq[t]);
            if (take > rem) begin
                exp_err = 1'b1;
                take    = rem;
            end
            repeat (take) bits.push_back(cur);
            cur = ~cur;
        end
        for (int b = 0; b < total; b += DATA_W) begin
            w = '0;
            for (int j = 0; j < DATA_W; j++) begin
                if (b + j < total) w[j] = bits[b + j];
            end
            expq.push_back(w);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Runs one frame from tokq. Expectations come from expq/exp_err/exp_used,
    // either filled by hand or by the reference model.
    task automatic run_frame(input int total, input bit rnd, input bit use_model);
        int                ti;
        int                wi;
        int                cyc;
        bit                fin;
        bit                prev_hold;
        logic [DATA_W-1:0] prev_data;
        if (use_model) build_model(total);
        @(negedge clk);
        start      = 1'b1;
        total_bits = TOT_W'(total);
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'(1));
        chk("err_cleared", 64'(err), 64'(0));
        ti = 0; wi = 0; cyc = 0; fin = 1'b0; prev_hold = 1'b0; prev_data = '0;
        while (!fin && cyc < 3000) begin
            if (done) begin
                fin = 1'b1;
            end else begin
                if (prev_hold) begin
                    chk("hold_valid", {47'd0, out_valid, out_data}, {47'd0, 1'b1, prev_data});
                end
                out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (ti < tokq.size() && (!rnd || $urandom_range(0, 3) != 0)) begin
                    in_valid = 1'b1;
                    in_data  = tokq[ti];
                end else begin
                    in_valid = 1'b0;
                end
                if (in_valid && in_ready) ti++;
                if (out_valid && out_ready && wi < expq.size()) begin
                    chk($sformatf("word%0d", wi), 64'(out_data), 64'(expq[wi]));
                end
                if (out_valid && out_ready) wi++;
                prev_hold = out_valid && !out_ready;
                prev_data = out_data;
                @(negedge clk);
                cyc++;
            end
        end
        last_cyc = cyc;
        chk("done_seen", 64'(fin), 64'(1));
        if (!fin) begin
            in_valid = 1'b0;
            do_reset();
            return;
        end
        chk("word_count", 64'(wi), 64'(expq.size()));
        chk("tokens_used", 64'(ti), 64'(exp_used));
        chk("err_at_done", 64'(err), 64'(exp_err));
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("busy_idle", 64'(busy), 64'(0));
        chk("done_one_cycle", 64'(done), 64'(0));
        chk("err_sticky", 64'(err), 64'(exp_err));
    endtask

    initial begin : main
        int ti;
        int cyc;
        int total;
        int sum;
        int r;
        rst        = 1'b1;
        start      = 1'b0;
        total_bits = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single word, alternating runs
        tokq = '{16'd1, 16'd3, 16'd5, 16'd8};
        expq = '{16'hFF07}; exp_err = 1'b0; exp_used = 4;
        run_frame(16, 1'b0, 1'b0);

        // Run spanning a word boundary
        tokq = '{16'd0, 16'd20, 16'd12};
        expq = '{16'h0000, 16'hFFF0}; exp_err = 1'b0; exp_used = 3;
        run_frame(32, 1'b0, 1'b0);

        // Partial flush, surplus token left pending
        tokq = '{16'd1, 16'd10, 16'd5};
        expq = '{16'h03FF}; exp_err = 1'b0; exp_used = 2;
        run_frame(10, 1'b0, 1'b0);

        // Zero-length run toggles the bit value
        tokq = '{16'd0, 16'd0, 16'd16};
        expq = '{16'hFFFF}; exp_err = 1'b0; exp_used = 3;
        run_frame(16, 1'b0, 1'b0);

        // Overrun truncation
        tokq = '{16'd0, 16'd4, 16'd9};
        expq = '{16'h00F0}; exp_err = 1'b1; exp_used = 3;
        run_frame(8, 1'b0, 1'b0);

        // Empty frame: done the cycle after start, no token taken
        tokq = '{16'd1};
        expq.delete(); exp_err = 1'b0; exp_used = 0;
        run_frame(0, 1'b0, 1'b0);
        chk("zero_done_latency", 64'(last_cyc), 64'(0));

        // Reset while filling an overrun run
        tokq = '{16'd0, 16'd9};
        @(negedge clk);
        start = 1'b1; total_bits = 32'd8; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ti = 0; cyc = 0;
        while (ti < 2 && cyc < 50) begin
            in_valid = 1'b1;
            in_data  = tokq[ti];
            if (in_ready) ti++;
            @(negedge clk);
            cyc++;
        end
        chk("mid_fill_reached", 64'(ti), 64'(2));
        chk("mid_fill_err_set", 64'(err), 64'(1));
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_in_ready", 64'(in_ready), 64'(0));
        chk("arst_out_valid", 64'(out_valid), 64'(0));
        chk("arst_out_data", 64'(out_data), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_done", 64'(done), 64'(0));
        chk("arst_err", 64'(err), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_no_word", 64'(out_valid), 64'(0));

        tokq = '{16'd1, 16'd3, 16'd5, 16'd8};
        expq = '{16'hFF07}; exp_err = 1'b0; exp_used = 4;
        run_frame(16, 1'b0, 1'b0);

        // Backpressure: word held for 5 cycles, then one handshake
        @(negedge clk);
        start = 1'b1; total_bits = 32'd16; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        ti = 0; cyc = 0;
        while (!out_valid && cyc < 100) begin
            if (ti < 4) begin
                in_valid = 1'b1;
                in_data  = tokq[ti];
            end else begin
                in_valid = 1'b0;
            end
            if (in_valid && in_ready) ti++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 64'(out_valid), 64'(1));
            chk("bp_data", 64'(out_data), 64'(16'hFF07));
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_single_hs", 64'(out_valid), 64'(0));
        chk("bp_done", 64'(done), 64'(1));
        @(negedge clk);
        chk("bp_idle", 64'(busy), 64'(0));

        // Randomized frames against the reference model
        for (int f = 0; f < 40; f++) begin
            total = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 100));
            tokq.delete();
            tokq.push_back(CNT_W'($urandom));
            sum = 0;
            while (sum < total) begin
                r = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 40));
                tokq.push_back(CNT_W'(r));
                sum += r;
            end
            repeat ($urandom_range(0, 2)) tokq.push_back(CNT_W'($urandom_range(0, 20)));
            run_frame(total, 1'b1, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
